// File: rtl/sipo_word_collector.sv
// Serial-to-parallel word framer: sync-aligned bit collection into WIDTH-bit
// words, with a one-entry valid/ready output buffer and a sticky overrun flag.
module sipo_word_collector #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             din,
    input  logic             din_valid,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             xfer;

    // A sync starts from an empty register so stale partial bits never leak
    // into the new word.
    always_comb begin
        base    = sync ? '0 : sh;
        shifted = '0;
        if (MSB_FIRST)
            shifted = {base[WIDTH-2:0], din};
        else
            shifted = {din, base[WIDTH-1:1]};
    end

    assign complete = (state == COLLECT) && din_valid && !sync &&
                      (cnt == CW'(WIDTH - 1));
    assign xfer     = word_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            sh         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (sync) begin
                state <= COLLECT;
                busy  <= 1'b1;
                sh    <= din_valid ? shifted : '0;
                cnt   <= din_valid ? CW'(1) : '0;
            end else if (state == COLLECT && din_valid) begin
                sh  <= shifted;
                cnt <= complete ? '0 : cnt + 1'b1;
            end

            if (complete && (!word_valid || xfer)) begin
                word       <= shifted;
                word_valid <= 1'b1;
            end else if (xfer) begin
                word_valid <= 1'b0;
            end

            // A drop on the same edge as clr_ovr still leaves the flag set.
            if (complete && word_valid && !out_ready)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_word_collector.sv
// Directed bench: MSB-first and LSB-first instances share stimulus; expected
// words are hand-derived from the bit sequences.
module tb_sipo_word_collector;

    logic       clk = 1'b0;
    logic       rst_n, sync, din, din_valid, out_ready, clr_ovr;
    logic [3:0] word_m, word_l;
    logic       vld_m, vld_l, ovr_m, ovr_l, busy_m, busy_l;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    sipo_word_collector #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .sync(sync), .din(din), .din_valid(din_valid),
        .out_ready(out_ready), .clr_ovr(clr_ovr), .word(word_m),
        .word_valid(vld_m), .overrun(ovr_m), .busy(busy_m));

    sipo_word_collector #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .sync(sync), .din(din), .din_valid(din_valid),
        .out_ready(out_ready), .clr_ovr(clr_ovr), .word(word_l),
        .word_valid(vld_l), .overrun(ovr_l), .busy(busy_l));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of serial input, then sample 1 time unit after the edge.
    task automatic step(input logic s, input logic v, input logic d);
        sync = s; din_valid = v; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; sync = 1'b0; din = 1'b0; din_valid = 1'b0;
        out_ready = 1'b1; clr_ovr = 1'b0;
        #12;
        chk("rst_word", {word_m, word_l}, 8'h00);
        chk("rst_flags", {vld_m, ovr_m, busy_m, vld_l, ovr_l, busy_l}, 6'b0);
        rst_n = 1'b1;
        idle(1);
        chk("idle_busy", busy_m, 1'b0);

        // 1/2: back-to-back bits 1,0,1,1
        step(1'b1, 1'b1, 1'b1);
        chk("t1_busy", {busy_m, busy_l}, 2'b11);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("t1_notyet", {vld_m, vld_l}, 2'b00);
        step(1'b0, 1'b1, 1'b1);
        chk("t1_valid", {vld_m, vld_l}, 2'b11);
        chk("t1_word_msb", word_m, 4'b1011);
        chk("t2_word_lsb", word_l, 4'b1101);
        idle(1);
        chk("t1_consumed", {vld_m, vld_l}, 2'b00);

        // 3: two idle cycles between valid bits
        step(1'b1, 1'b1, 1'b1); idle(2);
        step(1'b0, 1'b1, 1'b0); idle(2);
        step(1'b0, 1'b1, 1'b1); idle(2);
        chk("t3_notyet", vld_m, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("t3_valid", vld_m, 1'b1);
        chk("t3_word", word_m, 4'b1011);
        idle(1);

        // 4: backpressure, drop, clear colliding with drop
        out_ready = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("t4_first", {vld_m, word_m, word_l}, 9'b1_1011_1101);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("t4_no_ovr_yet", ovr_m, 1'b0);
        clr_ovr = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        clr_ovr = 1'b0;
        chk("t4_held_word", {word_m, word_l}, 8'b1011_1101);
        chk("t4_overrun", {ovr_m, ovr_l, vld_m}, 3'b111);
        out_ready = 1'b1;
        idle(1);
        chk("t4_consumed", {vld_m, vld_l}, 2'b00);
        chk("t4_word_kept", word_m, 4'b1011);
        chk("t4_ovr_sticky", ovr_m, 1'b1);
        clr_ovr = 1'b1;
        idle(1);
        clr_ovr = 1'b0;
        chk("t4_ovr_clr", {ovr_m, ovr_l}, 2'b00);

        // 5: partial frame aborted by sync
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("t5_partial", {vld_m, vld_l}, 2'b00);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("t5_notyet", vld_m, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("t5_word", {vld_m, word_m, word_l}, 9'b1_0100_0010);

        // 6: async reset mid-frame while a word is still pending
        out_ready = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("t6_pre", {vld_m, busy_m}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_word", {word_m, word_l}, 8'h00);
        chk("t6_rst_flags", {vld_m, ovr_m, busy_m, vld_l, ovr_l, busy_l}, 6'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("t6_nosync", {vld_m, vld_l, busy_m, busy_l}, 4'b0000);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
